// File: rtl/cva5_types.sv
// Shared types for the return-address stack: checkpoint record and index width.
package cva5_types;
  localparam int RAS_DEPTH_DEF = 8;
  localparam int RAS_INDEX_W   = $clog2(RAS_DEPTH_DEF);

  typedef struct packed {
    logic [RAS_INDEX_W-1:0] read_index;
    logic [RAS_INDEX_W:0]   count;
  } ras_ckpt_t;
endpackage

// File: rtl/lutram_1w_1r.sv
// Distributed RAM: one synchronous write port, one asynchronous read port, no reset.
module lutram_1w_1r #(
  parameter int  DEPTH     = 8,
  parameter type DATA_TYPE = logic [31:0]
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     ram_write,
  input  DATA_TYPE                 new_ram_data,
  output DATA_TYPE                 ram_data_out
);
  DATA_TYPE r_ram [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_write) r_ram[waddr] <= new_ram_data;
  end

  assign ram_data_out = r_ram[raddr];
endmodule

// File: rtl/ras_ckpt_fifo.sv
// Circular checkpoint queue for in-flight branches; clear empties it in one cycle.
module ras_ckpt_fifo
  import cva5_types::*;
#(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      wr,
  input  logic      rd,
  input  ras_ckpt_t data_in,
  output ras_ckpt_t data_out,
  output logic      empty,
  output logic      full
);
  localparam int PW = $clog2(DEPTH);

  ras_ckpt_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_occ;
  logic            w_wr;
  logic            w_rd;

  assign empty = (r_occ == '0);
  assign full  = (r_occ == (PW+1)'(DEPTH));

  // Illegal requests are dropped here so the caller need not guard them.
  assign w_rd = rd & ~empty;
  assign w_wr = wr & (~full | w_rd);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)      r_occ <= r_occ + 1'b1;
      else if (w_rd && !w_wr) r_occ <= r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !rst && !clr) r_mem[r_wptr] <= data_in;
  end

  assign data_out = r_mem[r_rptr];
endmodule

// File: rtl/return_address_stack.sv
// Speculative return-address stack with per-branch pointer checkpoints restored on early flush.
module return_address_stack
  import cva5_types::*;
#(
  parameter int RAS_DEPTH  = RAS_DEPTH_DEF,  // must equal 2**RAS_INDEX_W
  parameter int CKPT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] new_addr,
  input  logic        branch_fetched,
  input  logic        branch_retired,
  input  logic        early_branch_flush,
  output logic [31:0] addr,
  output logic        valid,
  output logic        ckpt_full
);
  localparam logic [RAS_INDEX_W:0] CNT_MAX = (RAS_INDEX_W+1)'(RAS_DEPTH);

  logic [RAS_INDEX_W-1:0] r_read_index;
  logic [RAS_INDEX_W:0]   r_count;
  logic [RAS_INDEX_W-1:0] w_next_index;
  logic [RAS_INDEX_W:0]   w_next_count;
  logic [RAS_INDEX_W-1:0] w_waddr;
  logic                   w_wen;
  ras_ckpt_t              w_ckpt_in;
  ras_ckpt_t              w_ckpt_out;
  logic                   w_ckpt_empty;
  logic                   w_ckpt_full;

  always_comb begin
    w_next_index = r_read_index;
    w_next_count = r_count;
    w_wen        = 1'b0;
    w_waddr      = r_read_index + 1'b1;
    if (early_branch_flush) begin
      if (!w_ckpt_empty) begin
        w_next_index = w_ckpt_out.read_index;
        w_next_count = w_ckpt_out.count;
      end
    end else if (push && pop) begin
      // Call-through-return: replace the top in place.
      w_wen   = 1'b1;
      w_waddr = r_read_index;
    end else if (push) begin
      w_wen        = 1'b1;
      w_next_index = r_read_index + 1'b1;
      w_next_count = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
    end else if (pop && r_count != '0) begin
      w_next_index = r_read_index - 1'b1;
      w_next_count = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_index <= '0;
      r_count      <= '0;
    end else begin
      r_read_index <= w_next_index;
      r_count      <= w_next_count;
    end
  end

  lutram_1w_1r #(.DEPTH(RAS_DEPTH), .DATA_TYPE(logic [31:0])) u_stack (
    .clk          (clk),
    .waddr        (w_waddr),
    .raddr        (r_read_index),
    .ram_write    (w_wen & ~rst),
    .new_ram_data (new_addr),
    .ram_data_out (addr)
  );

  // Checkpoint captures the pointer as it will be after this cycle's push/pop.
  assign w_ckpt_in.read_index = w_next_index;
  assign w_ckpt_in.count      = w_next_count;

  ras_ckpt_fifo #(.DEPTH(CKPT_DEPTH)) u_ckpt (
    .clk      (clk),
    .rst      (rst),
    .clr      (early_branch_flush),
    .wr       (branch_fetched & ~early_branch_flush),
    .rd       (branch_retired & ~early_branch_flush),
    .data_in  (w_ckpt_in),
    .data_out (w_ckpt_out),
    .empty    (w_ckpt_empty),
    .full     (w_ckpt_full)
  );

  assign valid     = (r_count != '0);
  assign ckpt_full = w_ckpt_full;

  always_ff @(posedge clk) begin
    if (!rst && !early_branch_flush) begin
      assert (!(branch_fetched && w_ckpt_full && !branch_retired));
      assert (!(branch_retired && w_ckpt_empty));
    end
  end
endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack: stack ops, overflow, checkpoints and flush.
module tb_return_address_stack;
  logic        clk = 1'b0;
  logic        rst, push, pop, branch_fetched, branch_retired, early_branch_flush;
  logic [31:0] new_addr;
  logic [31:0] addr;
  logic        valid, ckpt_full;
  int          n_cmp = 0;
  int          n_bad = 0;

  return_address_stack #(.RAS_DEPTH(8), .CKPT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
    .branch_fetched(branch_fetched), .branch_retired(branch_retired),
    .early_branch_flush(early_branch_flush),
    .addr(addr), .valid(valid), .ckpt_full(ckpt_full)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, then return inputs to idle.
  task automatic cyc(input logic p, input logic po, input logic [31:0] a,
                     input logic bf, input logic br, input logic fl);
    push = p; pop = po; new_addr = a;
    branch_fetched = bf; branch_retired = br; early_branch_flush = fl;
    @(posedge clk); #1;
    push = 0; pop = 0; new_addr = 0;
    branch_fetched = 0; branch_retired = 0; early_branch_flush = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_cmp++; if (ckpt_full !== 1'b0) begin n_bad++; $display("FAIL reset_ckpt_full got %b exp 0", ckpt_full); end
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_a [2];
    exp_a[0] = 32'h200; exp_a[1] = 32'h100;
    do_reset();
    cyc(1, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 32'h200, 0, 0, 0);
    cyc(1, 0, 32'h300, 0, 0, 0);
    n_cmp++; if (addr !== 32'h300 || valid !== 1'b1) begin n_bad++; $display("FAIL push3 got %h/%b exp 300/1", addr, valid); end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      n_cmp++; if (addr !== exp_a[i] || valid !== 1'b1) begin n_bad++; $display("FAIL pop%0d got %h/%b exp %h/1", i, addr, valid, exp_a[i]); end
    end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL pop_empty valid got %b exp 0", valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1, 0, 32'(i * 16), 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (addr !== 32'(32'h90 - k * 16) || valid !== 1'b1) begin n_bad++; $display("FAIL ovf_pop%0d got %h/%b exp %h/1", k, addr, valid, 32'h90 - k * 16); end
      cyc(0, 1, 0, 0, 0, 0);
    end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained valid got %b exp 0", valid); end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL underflow valid got %b exp 0", valid); end
    // Underflow must not move the pointer: next push lands above the old slot and is readable.
    cyc(1, 0, 32'hEE, 0, 0, 0);
    n_cmp++; if (addr !== 32'hEE || valid !== 1'b1) begin n_bad++; $display("FAIL push_after_underflow got %h/%b exp ee/1", addr, valid); end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL pop_after_underflow valid got %b exp 0", valid); end
  endtask

  task automatic test_call_through_return();
    do_reset();
    cyc(1, 0, 32'hA0, 0, 0, 0);
    cyc(1, 1, 32'hB0, 0, 0, 0);
    n_cmp++; if (addr !== 32'hB0 || valid !== 1'b1) begin n_bad++; $display("FAIL ctr_top got %h/%b exp b0/1", addr, valid); end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ctr_count valid got %b exp 0", valid); end
  endtask

  task automatic test_flush_restore();
    do_reset();
    cyc(1, 0, 32'hA0, 1, 0, 0);
    cyc(1, 0, 32'hB0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL pre_flush valid got %b exp 0", valid); end
    cyc(0, 0, 0, 0, 0, 1);
    n_cmp++; if (addr !== 32'hA0 || valid !== 1'b1 || ckpt_full !== 1'b0) begin n_bad++; $display("FAIL flush_restore got %h/%b/%b exp a0/1/0", addr, valid, ckpt_full); end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL flush_count valid got %b exp 0", valid); end
    // FIFO should be empty: a second flush must leave the pointer alone.
    cyc(1, 0, 32'hD0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    n_cmp++; if (addr !== 32'hD0 || valid !== 1'b1) begin n_bad++; $display("FAIL flush_empty_fifo got %h/%b exp d0/1", addr, valid); end
  endtask

  task automatic test_ckpt_full();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    n_cmp++; if (ckpt_full !== 1'b0) begin n_bad++; $display("FAIL ckpt3 full got %b exp 0", ckpt_full); end
    cyc(0, 0, 0, 1, 0, 0);
    n_cmp++; if (ckpt_full !== 1'b1) begin n_bad++; $display("FAIL ckpt4 full got %b exp 1", ckpt_full); end
    cyc(0, 0, 0, 1, 1, 0);
    n_cmp++; if (ckpt_full !== 1'b1) begin n_bad++; $display("FAIL ckpt_fetch_retire full got %b exp 1", ckpt_full); end
    cyc(0, 0, 0, 0, 1, 0);
    n_cmp++; if (ckpt_full !== 1'b0) begin n_bad++; $display("FAIL ckpt_retire full got %b exp 0", ckpt_full); end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_retire_order();
    do_reset();
    cyc(1, 0, 32'h11, 1, 0, 0);  // ckpt {1,1}
    cyc(1, 0, 32'h22, 1, 0, 0);  // ckpt {2,2}
    cyc(1, 0, 32'h33, 0, 1, 0);  // retire {1,1}
    cyc(0, 0, 0, 0, 0, 1);
    n_cmp++; if (addr !== 32'h22 || valid !== 1'b1) begin n_bad++; $display("FAIL retire_order got %h/%b exp 22/1", addr, valid); end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++; if (addr !== 32'h11 || valid !== 1'b1) begin n_bad++; $display("FAIL retire_order_pop got %h/%b exp 11/1", addr, valid); end
  endtask

  task automatic test_flush_ignores();
    do_reset();
    cyc(1, 0, 32'h11, 1, 0, 0);  // ckpt {1,1}
    cyc(1, 0, 32'h22, 1, 0, 0);
    cyc(1, 0, 32'h33, 0, 0, 0);
    cyc(1, 0, 32'hC0, 1, 0, 1);
    n_cmp++; if (addr !== 32'h11 || valid !== 1'b1 || ckpt_full !== 1'b0) begin n_bad++; $display("FAIL flush_ign got %h/%b/%b exp 11/1/0", addr, valid, ckpt_full); end
    cyc(1, 0, 32'h44, 0, 0, 1);
    n_cmp++; if (addr !== 32'h11) begin n_bad++; $display("FAIL flush_ign_empty got %h exp 11", addr); end
    cyc(1, 0, 32'h55, 0, 0, 0);
    n_cmp++; if (addr !== 32'h55) begin n_bad++; $display("FAIL post_flush_push got %h exp 55", addr); end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++; if (addr !== 32'h11 || valid !== 1'b1) begin n_bad++; $display("FAIL post_flush_pop got %h/%b exp 11/1", addr, valid); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 1, 0, 0);
    rst = 1;
    cyc(1, 0, 32'h77, 1, 0, 0);
    rst = 0;
    n_cmp++; if (valid !== 1'b0 || ckpt_full !== 1'b0) begin n_bad++; $display("FAIL reset_mid got %b/%b exp 0/0", valid, ckpt_full); end
    cyc(0, 0, 0, 0, 0, 1);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_fifo valid got %b exp 0", valid); end
  endtask

  initial begin
    rst = 1; push = 0; pop = 0; new_addr = 0;
    branch_fetched = 0; branch_retired = 0; early_branch_flush = 0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_call_through_return();
    test_flush_restore();
    test_ckpt_full();
    test_retire_order();
    test_flush_ignores();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
